// File: rtl/pipe_viterbi_pkg.sv
// Shared types and widths for the PipeViterbi frame controller.
package pipe_viterbi_pkg;

  localparam int unsigned SYM_W = 16;
  localparam int unsigned DEC_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    TAIL,
    DRAIN,
    CLEAR
  } vfc_state_t;

  typedef struct packed {
    logic v;
    logic l;
  } vit_tag_t;

endpackage

// File: rtl/vit_tag_pipe.sv
// Fixed-depth shift register of {valid,last} tags that tracks the decoder latency.
module vit_tag_pipe
  import pipe_viterbi_pkg::*;
#(
  parameter int unsigned DEPTH = 11
) (
  input  logic     clk,
  input  logic     clr,
  input  vit_tag_t din,
  output vit_tag_t dout
);

  vit_tag_t stage [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer feeding the PipeViterbi core: payload, zero tail, drain, decoder clear.
// Optional frame/gap statistics ports are enabled by defining VITERBI_FRAME_STATS_EN.
module viterbi_frame_ctrl
  import pipe_viterbi_pkg::*;
#(
  parameter int unsigned FRAME_LEN = 32,
  parameter int unsigned TAIL_LEN  = 1,
  parameter int unsigned DEC_LAT   = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [SYM_W-1:0] s_data,
  output logic             dec_rst,
  output logic             dec_valid,
  output logic [SYM_W-1:0] dec_data,
  input  logic [DEC_W-1:0] dec_out,
  output logic             m_valid,
  output logic [DEC_W-1:0] m_data,
  output logic             m_last,
  output logic             busy
`ifdef VITERBI_FRAME_STATS_EN
  ,
  output logic [15:0]      frame_cnt,
  output logic [15:0]      gap_cnt
`endif
);

  localparam int unsigned WCNT_W = $clog2(FRAME_LEN + 1);
  localparam int unsigned TCNT_W = 4;
  localparam int unsigned DCNT_W = $clog2(DEC_LAT + 2);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(FRAME_LEN - 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TAIL_LEN - 1);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEC_LAT + 1);

  // A one-word frame would need IDLE to jump straight past LOAD.
  generate
    if (FRAME_LEN < 2 || FRAME_LEN > 1024 || TAIL_LEN > 15 || DEC_LAT < 1 || DEC_LAT > 64)
    begin : g_bad_cfg
      $error("viterbi_frame_ctrl: parameter out of range");
    end
  endgenerate

  vfc_state_t        state, state_n;
  logic [WCNT_W-1:0] wcnt, wcnt_n;
  logic [TCNT_W-1:0] tcnt, tcnt_n;
  logic [DCNT_W-1:0] dcnt, dcnt_n;
  logic              accept, last_word, clr_pulse;
  vit_tag_t          tag_in, tag_out;

  assign accept    = s_valid && s_ready;
  assign last_word = accept && (wcnt == WCNT_LAST);
  assign dec_rst   = rst | clr_pulse;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wcnt  <= '0;
      tcnt  <= '0;
      dcnt  <= '0;
    end else begin
      state <= state_n;
      wcnt  <= wcnt_n;
      tcnt  <= tcnt_n;
      dcnt  <= dcnt_n;
    end
  end

  always_comb begin
    state_n = state;
    wcnt_n  = wcnt;
    tcnt_n  = tcnt;
    dcnt_n  = dcnt;
    unique case (state)
      IDLE: if (accept) begin
        wcnt_n  = WCNT_W'(1);
        state_n = LOAD;
      end
      LOAD: if (accept) begin
        if (wcnt == WCNT_LAST) begin
          wcnt_n  = '0;
          state_n = (TAIL_LEN > 0) ? TAIL : DRAIN;
        end else begin
          wcnt_n = wcnt + WCNT_W'(1);
        end
      end
      TAIL: if (tcnt == TCNT_LAST) begin
        tcnt_n  = '0;
        state_n = DRAIN;
      end else begin
        tcnt_n = tcnt + TCNT_W'(1);
      end
      // Hold off the clear until the last tagged byte has left m_valid.
      DRAIN: if (dcnt == DCNT_LAST) begin
        dcnt_n  = '0;
        state_n = CLEAR;
      end else begin
        dcnt_n = dcnt + DCNT_W'(1);
      end
      CLEAR:   state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Control outputs are registered decodes of the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_ready   <= 1'b1;
      busy      <= 1'b0;
      clr_pulse <= 1'b0;
      dec_valid <= 1'b0;
      dec_data  <= '0;
      tag_in    <= '0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      m_data    <= '0;
    end else begin
      s_ready   <= (state_n == IDLE) || (state_n == LOAD);
      busy      <= (state_n != IDLE);
      clr_pulse <= (state_n == CLEAR);
      if (accept) begin
        dec_valid <= 1'b1;
        dec_data  <= s_data;
      end else if (state == TAIL) begin
        dec_valid <= 1'b1;
        dec_data  <= '0;
      end else begin
        dec_valid <= 1'b0;
      end
      tag_in  <= '{v: accept, l: last_word};
      m_valid <= tag_out.v;
      m_last  <= tag_out.l;
      m_data  <= dec_out;
    end
  end

  vit_tag_pipe #(.DEPTH(DEC_LAT)) u_tag_pipe (
    .clk  (clk),
    .clr  (rst),
    .din  (tag_in),
    .dout (tag_out)
  );

`ifdef VITERBI_FRAME_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
      gap_cnt   <= '0;
    end else begin
      if (state == CLEAR) frame_cnt <= frame_cnt + 16'd1;
      if (state == IDLE && accept) gap_cnt <= '0;
      else if (state == LOAD && !s_valid && gap_cnt != 16'hFFFF) gap_cnt <= gap_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Bench for viterbi_frame_ctrl: cycle table for one frame, scoreboard for every decoded byte.
`timescale 1ns/1ps
module tb_viterbi_frame_ctrl;
  import pipe_viterbi_pkg::*;

  localparam int unsigned FL  = 4;
  localparam int unsigned LAT = 11;

  logic        clk = 1'b0;
  logic        rst, s_valid;
  logic [15:0] s_data;
  logic [7:0]  dec_out;
  logic        s_ready, dec_rst, dec_valid, m_valid, m_last, busy;
  logic [15:0] dec_data;
  logic [7:0]  m_data;
  logic        s_ready0, dec_rst0, dec_valid0, m_valid0, m_last0, busy0;
  logic [15:0] dec_data0;
  logic [7:0]  m_data0;
`ifdef VITERBI_FRAME_STATS_EN
  logic [15:0] frame_cnt, gap_cnt, frame_cnt0, gap_cnt0;
`endif

  always #5 clk = ~clk;

  viterbi_frame_ctrl #(.FRAME_LEN(FL), .TAIL_LEN(1), .DEC_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .dec_rst(dec_rst), .dec_valid(dec_valid), .dec_data(dec_data), .dec_out(dec_out),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .busy(busy)
`ifdef VITERBI_FRAME_STATS_EN
    , .frame_cnt(frame_cnt), .gap_cnt(gap_cnt)
`endif
  );

  viterbi_frame_ctrl #(.FRAME_LEN(FL), .TAIL_LEN(0), .DEC_LAT(LAT)) dut0 (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready0), .s_data(s_data),
    .dec_rst(dec_rst0), .dec_valid(dec_valid0), .dec_data(dec_data0), .dec_out(dec_out),
    .m_valid(m_valid0), .m_data(m_data0), .m_last(m_last0), .busy(busy0)
`ifdef VITERBI_FRAME_STATS_EN
    , .frame_cnt(frame_cnt0), .gap_cnt(gap_cnt0)
`endif
  );

  // Decoder stand-in: byte = data_recv[11:4], presented LAT cycles later.
  logic [7:0] hist [LAT];
  always @(posedge clk) begin
    hist[0] <= dec_data[11:4];
    for (int i = 1; i < LAT; i++) hist[i] <= hist[i-1];
  end
  assign dec_out = hist[LAT-1];

  int checks = 0, passes = 0, cyc = 0;
  always @(posedge clk) cyc++;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endfunction

  // Scoreboard: push on accept, pop on m_valid.
  typedef struct {
    logic [7:0] data;
    logic       last;
    int         due;
  } exp_t;
  exp_t sb[$];
  int   fidx = 0, mv_cnt = 0, ml_cnt = 0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      fidx = 0;
    end else begin
      if (s_valid && s_ready) begin
        sb.push_back('{data: s_data[11:4], last: (fidx == FL - 1), due: cyc + LAT + 2});
        fidx = (fidx == FL - 1) ? 0 : fidx + 1;
      end
      if (m_valid) begin
        mv_cnt++;
        if (m_last) ml_cnt++;
        check("sb_pending", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("sb_data", 32'(m_data), 32'(e.data));
          check("sb_last", 32'(m_last), 32'(e.last));
          check("sb_cycle", cyc, e.due);
        end
      end
    end
  end

  typedef struct {
    logic        sv;
    logic [15:0] sd;
    logic        rdy, dv, bsy, drst, mv, ml;
    logic [15:0] dd;
    logic        rdy0, dv0, bsy0, drst0, mv0, ml0;
    logic [15:0] dd0;
    logic [7:0]  md0;
  } vec_t;
  vec_t tbl [20];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_words(input int n, input int first, output int low);
    int  wait_n;
    bit  acc;
    low = 0;
    for (int k = 0; k < n; k++) begin
      s_valid = 1'b1;
      s_data  = 16'((first + k) * 32'h1111);
      wait_n  = 0;
      acc     = 1'b0;
      while (!acc && wait_n < 64) begin
        @(negedge clk);
        acc = s_ready;
        if (!acc) low++;
        tick();
        wait_n++;
      end
      check("send_ready", 32'(acc), 1);
      if (!acc) break;
    end
    s_valid = 1'b0;
  endtask

  task automatic bubble_frame(output logic [7:0] dvs);
    for (int i = 0; i < 8; i++) begin
      s_valid = (i < 2) || (i == 4) || (i == 5);
      s_data  = 16'(32'h0100 * (i + 1) + 32'h0050);
      @(negedge clk);
      dvs[i] = dec_valid;
      tick();
    end
    s_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          low;
    logic [7:0]  dvs;

    for (int i = 0; i < 20; i++) begin
      tbl[i].sv    = (i < 4);
      tbl[i].sd    = (i < 4) ? 16'((i + 1) * 32'h1111) : 16'h0;
      tbl[i].rdy   = (i < 4) || (i == 19);
      tbl[i].dv    = (i >= 1) && (i <= 5);
      tbl[i].dd    = (i >= 1 && i <= 4) ? 16'(i * 32'h1111) : 16'h0;
      tbl[i].bsy   = (i >= 1) && (i <= 18);
      tbl[i].drst  = (i == 18);
      tbl[i].mv    = (i >= 13) && (i <= 16);
      tbl[i].ml    = (i == 16);
      tbl[i].rdy0  = (i < 4) || (i >= 18);
      tbl[i].dv0   = (i >= 1) && (i <= 4);
      tbl[i].dd0   = (i == 0) ? 16'h0 : (i <= 4) ? 16'(i * 32'h1111) : 16'h4444;
      tbl[i].bsy0  = (i >= 1) && (i <= 17);
      tbl[i].drst0 = (i == 17);
      tbl[i].mv0   = (i >= 13) && (i <= 16);
      tbl[i].ml0   = (i == 16);
      tbl[i].md0   = 8'((i - 12) * 32'h11);
    end

    rst = 1'b1; s_valid = 1'b0; s_data = '0;
    repeat (3) tick();
    @(negedge clk);
    check("rst_dec_rst", 32'(dec_rst), 1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_s_ready", 32'(s_ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_dec_valid", 32'(dec_valid), 0);
    check("rst_dec_data", 32'(dec_data), 0);
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_m_last", 32'(m_last), 0);
    check("rst_m_data", 32'(m_data), 0);
    check("rst_dec_rst_low", 32'(dec_rst), 0);
    tick();

    // One clean frame, cycle by cycle, on both tail configurations.
    for (int i = 0; i < 20; i++) begin
      s_valid = tbl[i].sv;
      s_data  = tbl[i].sd;
      @(negedge clk);
      check($sformatf("t1_s_ready[%0d]", i), 32'(s_ready), 32'(tbl[i].rdy));
      check($sformatf("t1_dec_valid[%0d]", i), 32'(dec_valid), 32'(tbl[i].dv));
      check($sformatf("t1_dec_data[%0d]", i), 32'(dec_data), 32'(tbl[i].dd));
      check($sformatf("t1_busy[%0d]", i), 32'(busy), 32'(tbl[i].bsy));
      check($sformatf("t1_dec_rst[%0d]", i), 32'(dec_rst), 32'(tbl[i].drst));
      check($sformatf("t1_m_valid[%0d]", i), 32'(m_valid), 32'(tbl[i].mv));
      check($sformatf("t1_m_last[%0d]", i), 32'(m_last), 32'(tbl[i].ml));
      check($sformatf("t0_s_ready[%0d]", i), 32'(s_ready0), 32'(tbl[i].rdy0));
      check($sformatf("t0_dec_valid[%0d]", i), 32'(dec_valid0), 32'(tbl[i].dv0));
      check($sformatf("t0_dec_data[%0d]", i), 32'(dec_data0), 32'(tbl[i].dd0));
      check($sformatf("t0_busy[%0d]", i), 32'(busy0), 32'(tbl[i].bsy0));
      check($sformatf("t0_dec_rst[%0d]", i), 32'(dec_rst0), 32'(tbl[i].drst0));
      check($sformatf("t0_m_valid[%0d]", i), 32'(m_valid0), 32'(tbl[i].mv0));
      check($sformatf("t0_m_last[%0d]", i), 32'(m_last0), 32'(tbl[i].ml0));
      if (tbl[i].mv0) check($sformatf("t0_m_data[%0d]", i), 32'(m_data0), 32'(tbl[i].md0));
      tick();
    end

    // Two-cycle input gap inside a frame.
    mv_cnt = 0; ml_cnt = 0;
    bubble_frame(dvs);
    check("t2_dec_valid_pattern", 32'(dvs), 32'h0E6);
    repeat (25) tick();
    check("t2_m_valid_count", mv_cnt, 4);
    check("t2_m_last_count", ml_cnt, 1);

    // Reset in the middle of LOAD discards the partial frame.
    mv_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = 16'(32'h0910 + 32'h10 * i);
      tick();
    end
    s_valid = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    check("t4_dec_rst_in_rst", 32'(dec_rst), 1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t4_s_ready_after", 32'(s_ready), 1);
    check("t4_busy_after", 32'(busy), 0);
    check("t4_dec_valid_after", 32'(dec_valid), 0);
    repeat (20) tick();
    check("t4_no_m_valid", mv_cnt, 0);

    // s_valid held high across the frame boundary.
    mv_cnt = 0; ml_cnt = 0;
    send_words(8, 1, low);
    check("t5_ready_low_cycles", low, 15);
    repeat (25) tick();
    check("t5_m_valid_count", mv_cnt, 8);
    check("t5_m_last_count", ml_cnt, 2);
    check("t5_sb_empty", sb.size(), 0);

`ifdef VITERBI_FRAME_STATS_EN
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    send_words(12, 1, low);
    repeat (25) tick();
    check("st_frame_cnt_3", 32'(frame_cnt), 3);
    bubble_frame(dvs);
    repeat (25) tick();
    check("st_gap_cnt", 32'(gap_cnt), 2);
    check("st_frame_cnt_4", 32'(frame_cnt), 4);
    force dut.frame_cnt = 16'hFFFF;
    tick();
    release dut.frame_cnt;
    send_words(4, 3, low);
    repeat (25) tick();
    check("st_frame_cnt_wrap", 32'(frame_cnt), 0);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
